// File: rtl/ysyx_22041211_ifu.sv
`default_nettype none
// ============================================================================
// Module   : ysyx_22041211_ifu
// Brief    : Instruction fetch unit; one outstanding imem read, valid/ready
//            hand-off to decode, redirects from execute with priority.
// Revision : 1.0 - initial release
// ============================================================================
module ysyx_22041211_ifu #(
    parameter int          DATA_LEN = 32,
    parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
    input  logic                clk,
    input  logic                rst_n,
    output logic                imem_req_valid,
    input  logic                imem_req_ready,
    output logic [DATA_LEN-1:0] imem_req_addr,
    input  logic                imem_rsp_valid,
    input  logic [DATA_LEN-1:0] imem_rsp_data,
    input  logic                redirect_valid,
    input  logic [DATA_LEN-1:0] redirect_pc,
    output logic                inst_valid,
    input  logic                inst_ready,
    output logic [DATA_LEN-1:0] inst,
    output logic [DATA_LEN-1:0] inst_pc,
    output logic                fetch_err
);

    localparam logic [2:0] c_idle = 3'd0;
    localparam logic [2:0] c_req  = 3'd1;
    localparam logic [2:0] c_wait = 3'd2;
    localparam logic [2:0] c_hold = 3'd3;
    localparam logic [2:0] c_err  = 3'd4;

    localparam logic [DATA_LEN-1:0] c_pc_step  = DATA_LEN'(4);
    localparam logic [DATA_LEN-1:0] c_reset_pc = DATA_LEN'(RESET_PC);

    logic [2:0]          r_state;
    logic [DATA_LEN-1:0] r_pc;
    logic                r_drop;
    logic [DATA_LEN-1:0] r_inst;
    logic [DATA_LEN-1:0] r_inst_pc;
    logic                r_inst_valid;
    logic                r_fetch_err;

    logic [2:0]          w_state_nxt;
    logic [DATA_LEN-1:0] w_pc_nxt;
    logic                w_drop_nxt;
    logic [DATA_LEN-1:0] w_inst_nxt;
    logic [DATA_LEN-1:0] w_inst_pc_nxt;
    logic                w_inst_valid_nxt;
    logic                w_fetch_err_nxt;
    logic                w_redirect;
    logic                w_misaligned;

    assign w_redirect   = redirect_valid && (r_state != c_err);
    assign w_misaligned = (redirect_pc[1:0] != 2'b00);

    // State register together with the datapath registers it steers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= c_idle;
            r_pc         <= c_reset_pc;
            r_drop       <= 1'b0;
            r_inst       <= '0;
            r_inst_pc    <= '0;
            r_inst_valid <= 1'b0;
            r_fetch_err  <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_pc         <= w_pc_nxt;
            r_drop       <= w_drop_nxt;
            r_inst       <= w_inst_nxt;
            r_inst_pc    <= w_inst_pc_nxt;
            r_inst_valid <= w_inst_valid_nxt;
            r_fetch_err  <= w_fetch_err_nxt;
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_pc_nxt         = r_pc;
        w_drop_nxt       = r_drop;
        w_inst_nxt       = r_inst;
        w_inst_pc_nxt    = r_inst_pc;
        w_inst_valid_nxt = r_inst_valid;
        w_fetch_err_nxt  = r_fetch_err;

        if (w_redirect) begin
            w_inst_valid_nxt = 1'b0;
            if (w_misaligned) begin
                w_fetch_err_nxt = 1'b1;
                w_state_nxt     = c_err;
            end else begin
                w_pc_nxt    = redirect_pc;
                w_state_nxt = c_req;
                // A request already in flight must have its response swallowed
                case (r_state)
                    c_req: begin
                        if (imem_req_ready) begin
                            w_state_nxt = c_wait;
                            w_drop_nxt  = 1'b1;
                        end
                    end
                    c_wait: begin
                        if (!imem_rsp_valid) begin
                            w_state_nxt = c_wait;
                            w_drop_nxt  = 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end else begin
            case (r_state)
                c_idle: w_state_nxt = c_req;
                c_req: begin
                    if (imem_req_ready) begin
                        w_state_nxt = c_wait;
                    end
                end
                c_wait: begin
                    if (imem_rsp_valid) begin
                        if (r_drop) begin
                            w_drop_nxt  = 1'b0;
                            w_state_nxt = c_req;
                        end else begin
                            w_inst_nxt       = imem_rsp_data;
                            w_inst_pc_nxt    = r_pc;
                            w_inst_valid_nxt = 1'b1;
                            w_pc_nxt         = r_pc + c_pc_step;
                            w_state_nxt      = c_hold;
                        end
                    end
                end
                c_hold: begin
                    if (r_inst_valid && inst_ready) begin
                        w_inst_valid_nxt = 1'b0;
                        w_state_nxt      = c_req;
                    end
                end
                c_err: begin
                    w_inst_valid_nxt = 1'b0;
                end
                default: w_state_nxt = c_idle;
            endcase
        end
    end

    always_comb begin
        imem_req_valid = (r_state == c_req);
    end

    assign imem_req_addr = r_pc;
    assign inst_valid    = r_inst_valid;
    assign inst          = r_inst;
    assign inst_pc       = r_inst_pc;
    assign fetch_err     = r_fetch_err;

endmodule
`default_nettype wire
